// File: rtl/pc_flow_ctrl_if.sv
// Control bundle between pc_flow_ctrl and the PC / pipeline-register side of the core.
// master: the flow controller; slave: the pipeline and hazard sources it serves.
interface pc_flow_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             branchTaken;
    logic             loadUseHazard;
    logic             imemReady;
    logic             dmemReady;
    logic             pcSelect;
    logic             pcStall;
    logic             ifIdStall;
    logic             ifIdFlush;
    logic             idExStall;
    logic             idExFlush;
    logic             exMemStall;
    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] flushEvents;

    modport master (
        input  branchTaken, loadUseHazard, imemReady, dmemReady,
        output pcSelect, pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall,
        output stallCycles, flushEvents
    );

    modport slave (
        output branchTaken, loadUseHazard, imemReady, dmemReady,
        input  pcSelect, pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall,
        input  stallCycles, flushEvents
    );
endinterface

// File: rtl/pc_flow_ctrl.sv
// Program-flow / hazard controller for the 5-stage core: PC select/stall plus pipeline stall/flush strobes.
// Define PC_FLOW_PERF_EN to build the stallCycles / flushEvents performance counters.
//
// state      | meaning
// RUN        | normal issue; load-use and fetch-wait hazards are handled here
// SQUASH     | post-branch window, IF/ID kept flushed until sq_cnt reaches 0
// LOAD_STALL | one-cycle shadow after a load-use stall; the hazard input is ignored
module pc_flow_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic           clk,
    input  logic           rstN,
    pc_flow_ctrl_if.master flow
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        SQUASH     = 2'd1,
        LOAD_STALL = 2'd2
    } state_t;

    localparam logic [3:0] SQ_LOAD     = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] sq_cnt;
    logic [3:0] sq_cnt_nxt;

    logic pc_select;
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;

    // Mealy decode: controls follow the inputs in the same cycle, first matching rule wins.
    always_comb begin
        pc_select    = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        state_nxt    = state;
        sq_cnt_nxt   = sq_cnt;

        if (!rstN) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = RUN;
            sq_cnt_nxt  = 4'd0;
        end else if (!flow.dmemReady) begin
            // Freeze: a taken branch stays parked in EX and is consumed afterwards.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (flow.branchTaken) begin
            pc_select   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (MULTI_FLUSH) begin
                state_nxt  = SQUASH;
                sq_cnt_nxt = SQ_LOAD;
            end else begin
                state_nxt  = RUN;
                sq_cnt_nxt = 4'd0;
            end
        end else if (state == SQUASH) begin
            if_id_flush = 1'b1;
            if (!flow.imemReady) begin
                pc_stall = 1'b1;
            end else if (sq_cnt <= 4'd1) begin
                state_nxt  = RUN;
                sq_cnt_nxt = 4'd0;
            end else begin
                sq_cnt_nxt = sq_cnt - 4'd1;
            end
        end else if ((state == RUN) && flow.loadUseHazard) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            state_nxt   = LOAD_STALL;
        end else begin
            // RUN without hazard, or the LOAD_STALL shadow cycle.
            state_nxt = RUN;
            if (!flow.imemReady) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state  <= RUN;
            sq_cnt <= 4'd0;
        end else begin
            state  <= state_nxt;
            sq_cnt <= sq_cnt_nxt;
        end
    end

    assign flow.pcSelect   = pc_select;
    assign flow.pcStall    = pc_stall;
    assign flow.ifIdStall  = if_id_stall;
    assign flow.ifIdFlush  = if_id_flush;
    assign flow.idExStall  = id_ex_stall;
    assign flow.idExFlush  = id_ex_flush;
    assign flow.exMemStall = ex_mem_stall;

`ifdef PC_FLOW_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             branch_fire;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    assign branch_fire = flow.dmemReady && flow.branchTaken;

    // Saturating counters: they stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (branch_fire && (flush_events != '1)) begin
                flush_events <= flush_events + CNT_ONE;
            end
        end
    end

    assign flow.stallCycles = stall_cycles;
    assign flow.flushEvents = flush_events;
`else
    assign flow.stallCycles = {CNT_W{1'b0}};
    assign flow.flushEvents = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Self-checking bench for pc_flow_ctrl: directed vector table, counter saturation sequence,
// and randomized traffic against a rule-level reference model on three parameterisations.
module tb_pc_flow_ctrl;
`ifdef PC_FLOW_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control vector bit order: {pcSelect, pcStall, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_RST  = 7'b0101010;
    localparam logic [6:0] C_BR   = 7'b1001010;
    localparam logic [6:0] C_SQ   = 7'b0001000;
    localparam logic [6:0] C_SQW  = 7'b0101000;
    localparam logic [6:0] C_LU   = 7'b0110010;
    localparam logic [6:0] C_FRZ  = 7'b0110101;
    localparam logic [6:0] C_IMW  = 7'b0101000;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    pc_flow_ctrl_if #(.CNT_W(32)) ifa ();
    pc_flow_ctrl_if #(.CNT_W(3))  ifb ();
    pc_flow_ctrl_if #(.CNT_W(2))  ifc ();

    pc_flow_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut_a (.clk(clk), .rstN(rstN), .flow(ifa));
    pc_flow_ctrl #(.FLUSH_CYCLES(3), .CNT_W(3))  dut_b (.clk(clk), .rstN(rstN), .flow(ifb));
    pc_flow_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2))  dut_c (.clk(clk), .rstN(rstN), .flow(ifc));

    logic [6:0]  act_ctrl  [3];
    logic [63:0] act_stall [3];
    logic [63:0] act_flush [3];

    assign act_ctrl[0] = {ifa.pcSelect, ifa.pcStall, ifa.ifIdStall, ifa.ifIdFlush, ifa.idExStall, ifa.idExFlush, ifa.exMemStall};
    assign act_ctrl[1] = {ifb.pcSelect, ifb.pcStall, ifb.ifIdStall, ifb.ifIdFlush, ifb.idExStall, ifb.idExFlush, ifb.exMemStall};
    assign act_ctrl[2] = {ifc.pcSelect, ifc.pcStall, ifc.ifIdStall, ifc.ifIdFlush, ifc.idExStall, ifc.idExFlush, ifc.exMemStall};
    assign act_stall[0] = 64'(ifa.stallCycles);
    assign act_stall[1] = 64'(ifb.stallCycles);
    assign act_stall[2] = 64'(ifc.stallCycles);
    assign act_flush[0] = 64'(ifa.flushEvents);
    assign act_flush[1] = 64'(ifb.flushEvents);
    assign act_flush[2] = 64'(ifc.flushEvents);

    // Reference model: remaining flush cycles after a branch, and whether the previous cycle
    // was a load-use stall (so the hazard input is ignored now).
    typedef struct {
        int          flush_left;
        bit          shadow;
        logic [63:0] stalls;
        logic [63:0] flushes;
    } mdl_t;

    mdl_t        mdl  [3];
    int          fcyc [3] = '{2, 3, 1};
    logic [63:0] cmax [3] = '{64'hFFFF_FFFF, 64'd7, 64'd3};

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          rst;
        bit          br;
        bit          lu;
        bit          im;
        bit          dm;
        logic [6:0]  exp;
        bit          chk;
        logic [63:0] es;
        logic [63:0] ef;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit br, bit lu, bit im, bit dm, logic [6:0] exp,
                                bit chk = 1'b0, logic [63:0] es = 64'd0, logic [63:0] ef = 64'd0);
        vec_t v;
        v.rst = rst; v.br = br; v.lu = lu; v.im = im; v.dm = dm;
        v.exp = exp; v.chk = chk; v.es = es; v.ef = ef;
        return v;
    endfunction

    task automatic chk7(input string name, input int m, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %b want %b", name, m, $time, got, want);
        end
    endtask

    task automatic chk64(input string name, input int m, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %0d want %0d", name, m, $time, got, want);
        end
    endtask

    task automatic drive(input bit rst, input bit br, input bit lu, input bit im, input bit dm);
        rstN = rst;
        ifa.branchTaken = br; ifa.loadUseHazard = lu; ifa.imemReady = im; ifa.dmemReady = dm;
        ifb.branchTaken = br; ifb.loadUseHazard = lu; ifb.imemReady = im; ifb.dmemReady = dm;
        ifc.branchTaken = br; ifc.loadUseHazard = lu; ifc.imemReady = im; ifc.dmemReady = dm;
    endtask

    // One clock: drive at the falling edge, sample 1 ns later, then advance the model.
    task automatic do_cycle(input bit rst, input bit br, input bit lu, input bit im, input bit dm,
                            input bit use_exp, input logic [6:0] exp, input string tag);
        logic [6:0] want;
        bit o_sel, o_pst, o_ifs, o_iff, o_ies, o_ief, o_ems;
        @(negedge clk);
        drive(rst, br, lu, im, dm);
        #1;
        if (use_exp) chk7(tag, 0, act_ctrl[0], exp);
        for (int m = 0; m < 3; m++) begin
            if (!rst) begin
                mdl[m].flush_left = 0;
                mdl[m].shadow     = 1'b0;
                mdl[m].stalls     = 64'd0;
                mdl[m].flushes    = 64'd0;
            end
            chk64("stallCycles", m, act_stall[m], PERF ? mdl[m].stalls : 64'd0);
            chk64("flushEvents", m, act_flush[m], PERF ? mdl[m].flushes : 64'd0);
            o_sel = 0; o_pst = 0; o_ifs = 0; o_iff = 0; o_ies = 0; o_ief = 0; o_ems = 0;
            if (!rst) begin
                o_pst = 1; o_iff = 1; o_ief = 1;
            end else if (!dm) begin
                o_pst = 1; o_ifs = 1; o_ies = 1; o_ems = 1;
            end else if (br) begin
                o_sel = 1; o_iff = 1; o_ief = 1;
                mdl[m].flush_left = fcyc[m] - 1;
                mdl[m].shadow     = 1'b0;
                if (mdl[m].flushes != cmax[m]) mdl[m].flushes++;
            end else if (mdl[m].flush_left > 0) begin
                o_iff = 1;
                if (!im) o_pst = 1;
                else mdl[m].flush_left--;
            end else if (!mdl[m].shadow && lu) begin
                o_pst = 1; o_ifs = 1; o_ief = 1;
                mdl[m].shadow = 1'b1;
            end else begin
                mdl[m].shadow = 1'b0;
                if (!im) begin
                    o_pst = 1; o_iff = 1;
                end
            end
            want = {o_sel, o_pst, o_ifs, o_iff, o_ies, o_ief, o_ems};
            chk7("model_ctrl", m, act_ctrl[m], want);
            if (rst && o_pst && (mdl[m].stalls != cmax[m])) mdl[m].stalls++;
        end
    endtask

    initial begin
        for (int m = 0; m < 3; m++) begin
            mdl[m].flush_left = 0;
            mdl[m].shadow     = 1'b0;
            mdl[m].stalls     = 64'd0;
            mdl[m].flushes    = 64'd0;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Directed table for the FLUSH_CYCLES=2 instance; counter columns are perf-build values.
        tbl.push_back(mk(0,0,0,1,1, C_RST, 1, 0, 0));
        tbl.push_back(mk(0,0,0,1,1, C_RST));
        tbl.push_back(mk(1,0,0,1,1, C_NONE));
        tbl.push_back(mk(1,1,0,1,1, C_BR));
        tbl.push_back(mk(1,0,0,1,1, C_SQ));
        tbl.push_back(mk(1,0,0,1,1, C_NONE, 1, 0, 1));
        tbl.push_back(mk(1,0,1,1,1, C_LU));
        tbl.push_back(mk(1,0,1,1,1, C_NONE));
        tbl.push_back(mk(1,0,0,1,1, C_NONE, 1, 1, 1));
        tbl.push_back(mk(1,1,0,1,0, C_FRZ));
        tbl.push_back(mk(1,1,0,1,0, C_FRZ));
        tbl.push_back(mk(1,1,0,1,0, C_FRZ));
        tbl.push_back(mk(1,1,0,1,1, C_BR));
        tbl.push_back(mk(1,0,0,1,1, C_SQ, 1, 4, 2));
        tbl.push_back(mk(1,0,0,1,1, C_NONE));
        tbl.push_back(mk(1,1,1,1,1, C_BR));
        tbl.push_back(mk(1,0,1,1,1, C_SQ));
        tbl.push_back(mk(1,0,0,1,1, C_NONE));
        tbl.push_back(mk(1,1,0,1,1, C_BR));
        tbl.push_back(mk(1,0,0,0,1, C_SQW));
        tbl.push_back(mk(1,0,0,0,1, C_SQW));
        tbl.push_back(mk(1,0,0,1,1, C_SQ));
        tbl.push_back(mk(1,0,0,1,1, C_NONE));
        tbl.push_back(mk(1,0,0,0,1, C_IMW));
        tbl.push_back(mk(1,1,0,1,1, C_BR));
        tbl.push_back(mk(0,0,0,1,1, C_RST));
        tbl.push_back(mk(1,0,0,1,1, C_NONE, 1, 0, 0));
        tbl.push_back(mk(1,0,0,1,1, C_NONE));
        tbl.push_back(mk(1,0,1,1,1, C_LU));
        tbl.push_back(mk(1,0,1,1,0, C_FRZ));
        tbl.push_back(mk(1,0,1,0,1, C_IMW));
        tbl.push_back(mk(1,0,1,1,1, C_LU));
        tbl.push_back(mk(1,0,0,1,1, C_NONE));
        tbl.push_back(mk(1,1,0,0,1, C_BR));
        tbl.push_back(mk(1,1,0,1,1, C_BR));
        tbl.push_back(mk(1,0,0,1,1, C_SQ));
        tbl.push_back(mk(1,0,0,1,1, C_NONE));

        foreach (tbl[i]) begin
            do_cycle(tbl[i].rst, tbl[i].br, tbl[i].lu, tbl[i].im, tbl[i].dm, 1'b1, tbl[i].exp,
                     $sformatf("vec%0d", i));
            if (tbl[i].chk) begin
                chk64($sformatf("vec%0d_stall", i), 0, act_stall[0], PERF ? tbl[i].es : 64'd0);
                chk64($sformatf("vec%0d_flush", i), 0, act_flush[0], PERF ? tbl[i].ef : 64'd0);
            end
        end

        // Counter saturation: 10 fetch-wait cycles and 5 back-to-back branches.
        do_cycle(0, 0, 0, 1, 1, 1'b1, C_RST, "sat_rst");
        for (int i = 0; i < 10; i++) do_cycle(1, 0, 0, 0, 1, 1'b1, C_IMW, "sat_imw");
        for (int i = 0; i < 5; i++)  do_cycle(1, 1, 0, 1, 1, 1'b1, C_BR, "sat_br");
        do_cycle(1, 0, 0, 1, 1, 1'b1, C_SQ, "sat_tail");
        chk64("sat_stall_w32", 0, act_stall[0], PERF ? 64'd10 : 64'd0);
        chk64("sat_stall_w3",  1, act_stall[1], PERF ? 64'd7  : 64'd0);
        chk64("sat_stall_w2",  2, act_stall[2], PERF ? 64'd3  : 64'd0);
        chk64("sat_flush_w32", 0, act_flush[0], PERF ? 64'd5  : 64'd0);
        chk64("sat_flush_w3",  1, act_flush[1], PERF ? 64'd5  : 64'd0);
        chk64("sat_flush_w2",  2, act_flush[2], PERF ? 64'd3  : 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            do_cycle(($urandom_range(0, 99) >= 1),
                     ($urandom_range(0, 99) < 15),
                     ($urandom_range(0, 99) < 25),
                     ($urandom_range(0, 99) < 80),
                     ($urandom_range(0, 99) < 85),
                     1'b0, C_NONE, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
- Program-flow and hazard controller for the 5-stage RISC-V core.
- Drives the PC-select mux controls `pcSelect` and `pcStall`, plus the pipeline-register stall and flush strobes.
- Inputs it arbitrates: branch resolution (EX), load-use hazard (ID), instruction-memory wait and data-memory wait.
- Sits beside the PC register and pipeline registers. It holds a small FSM for multi-cycle squash and stall sequencing, plus optional performance counters.

Parameters:
- FLUSH_CYCLES, 2, cycles `ifIdFlush` stays high after a taken branch, including the redirect cycle; legal range 1..15.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rstN  in  1  asynchronous, active-low reset.
- branchTaken  in  1  EX stage: branch/jump resolved taken this cycle.
- loadUseHazard  in  1  ID stage: source register matches a load destination in EX.
- imemReady  in  1  1 = fetched instruction valid this cycle.
- dmemReady  in  1  1 = MEM stage access complete; 0 = freeze the pipeline.
- pcSelect  out  1  1 = load the PC from the branch target.
- pcStall  out  1  1 = hold the PC (only meaningful when `pcSelect`=0).
- ifIdStall  out  1  hold the IF/ID register.
- ifIdFlush  out  1  load a bubble into IF/ID.
- idExStall  out  1  hold the ID/EX register.
- idExFlush  out  1  load a bubble into ID/EX.
- exMemStall  out  1  hold the EX/MEM register.
- stallCycles  out  CNT_W  cycles with `pcStall`=1.
- flushEvents  out  CNT_W  accepted taken branches.

Behaviour:
- State machine:
  - States: RUN, SQUASH, LOAD_STALL.
  - Down-counter `sqCnt`, 4 bits.
- Outputs are combinational from state and inputs (Mealy). Zero-cycle latency from input to control.
- Evaluation priority, first match wins each cycle:
  1. dmemReady=0 (freeze):
     - Drive `pcStall`, `ifIdStall`, `idExStall`, `exMemStall` = 1; `pcSelect` = 0; all flushes = 0.
     - State and `sqCnt` are held.
     - A pending `branchTaken` is not consumed; EX holds it until the freeze ends.
  2. branchTaken=1:
     - Drive `pcSelect`=1, `pcStall`=0, `ifIdFlush`=1, `idExFlush`=1.
     - `loadUseHazard` and `imemReady` are ignored.
     - If FLUSH_CYCLES>1: next state SQUASH, `sqCnt`=FLUSH_CYCLES-1. Otherwise next state RUN.
     - This applies from any state, so a branch in SQUASH restarts the count.
  3. state SQUASH:
     - Drive `ifIdFlush`=1; `loadUseHazard` is ignored.
     - If imemReady=0: additionally drive `pcStall`=1 and hold `sqCnt`.
     - Otherwise decrement `sqCnt`; the cycle that decrements it to 0 transitions to RUN.
  4. state RUN and loadUseHazard=1:
     - Drive `pcStall`=1, `ifIdStall`=1, `idExFlush`=1.
     - Next state LOAD_STALL.
  5. state LOAD_STALL:
     - `loadUseHazard` is ignored.
     - Otherwise handled as RUN with the hazard deasserted.
     - Always returns to RUN after exactly 1 cycle.
  6. imemReady=0: drive `pcStall`=1 and `ifIdFlush`=1.
  7. Otherwise: all control outputs 0.
- `pcSelect`=1 implies `pcStall`=0 in every case.
- Reset:
  - While rstN=0: state RUN, `sqCnt`=0, counters 0.
  - Outputs forced: `pcStall`=1, `ifIdFlush`=1, `idExFlush`=1, all others 0.
  - Reset mid-SQUASH or mid-LOAD_STALL aborts immediately; the first cycle after release is RUN.
- Counters:
  - `stallCycles` increments on each rising edge where `pcStall`=1 and rstN=1.
  - `flushEvents` increments on each rising edge where rule 2 fires.
  - Both saturate at 2^CNT_W-1; no wrap.

Optional Feature:
- Macro: PC_FLOW_PERF_EN.
- Defined: `stallCycles` and `flushEvents` are implemented as above.
- Undefined: no counter registers are built; both outputs are tied to 0. Control behaviour is identical.

Test Plan:
- Reset release with imemReady=1, dmemReady=1, other inputs 0 → all control outputs 0; counters 0. While rstN=0: `pcStall`=`ifIdFlush`=`idExFlush`=1.
- 1-cycle branchTaken, FLUSH_CYCLES=2:
  - c0: `pcSelect`=`ifIdFlush`=`idExFlush`=1.
  - c1: `ifIdFlush`=1 only.
  - c2: all 0.
  - `flushEvents`=1.
- loadUseHazard held high 2 cycles:
  - c0: `pcStall`=`ifIdStall`=`idExFlush`=1.
  - c1: all 0 (hazard ignored in LOAD_STALL).
  - `stallCycles`=1.
- dmemReady=0 for 3 cycles with branchTaken held → c0–c2 full freeze with `pcSelect`=0; c3 `pcSelect`=1; `stallCycles`=3.
- branchTaken and loadUseHazard in the same cycle → `pcSelect`=1, `pcStall`=0, `ifIdStall`=0; next state SQUASH.
- rstN pulsed low during SQUASH → after release, outputs all 0 with idle inputs; no residual `ifIdFlush`.
